burst_rom_slave: RTL

//  Parametrised Avalon-MM read-only slave over a synchronous ROM (matrix storage, one row per word).

---
 rtl/burst_rom_pkg.sv | 20 ++
 rtl/rom_sync_param.sv | 42 ++++
 rtl/burst_rom_slave.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/burst_rom_pkg.sv
// Shared types, response codes and burst-length helper for the burst ROM slave.
package burst_rom_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // A zero burstcount means one beat; oversize requests are cut to the largest legal burst.
  function automatic int unsigned clamp_burst(input int unsigned bc, input int unsigned max_burst);
    if (bc == 0) return 1;
    if (bc > max_burst) return max_burst;
    return bc;
  endfunction

endpackage

// File: rtl/rom_sync_param.sv
// Synchronous ROM: address registered, q one cycle later. Contents are the built-in matrix
// image (row i holds byte i in every lane); an empty INIT_FILE name yields a blank ROM.
module rom_sync_param
  import burst_rom_pkg::*;
#(
  parameter int    DATA_W    = 64,
  parameter int    DEPTH     = 8,
  parameter string INIT_FILE = "rom.mif",
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     addr_i,
  output logic [DATA_W-1:0] q_o
);

  function automatic logic [DATA_W-1:0] image_word(input int idx);
    logic [DATA_W-1:0] w;
    w = '0;
    if (INIT_FILE != "") begin
      for (int b = 0; b < DATA_W / 8; b++) w[b*8 +: 8] = 8'(idx);
    end
    return w;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     addr_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_image
    assign mem[i] = image_word(i);
  end

  // NOTE: only the address register is reset; the storage array has no reset so it can map
  // onto ROM/block RAM. Sequential state is always written with non-blocking (<=) assignments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) addr_q <= '0;
    else          addr_q <= addr_i;
  end

  assign q_o = mem[addr_q];

endmodule

// File: rtl/burst_rom_slave.sv
// Avalon-MM read-only burst slave over a synchronous ROM: delayed start, wrapping bursts,
// DECODEERROR for out-of-range starts, saturating accept counter.
module burst_rom_slave
  import burst_rom_pkg::*;
#(
  parameter int    DATA_W    = 64,
  parameter int    DEPTH     = 8,
  parameter int    ADDR_W    = 32,
  parameter int    DELAY     = 10,
  parameter int    MAX_BURST = 8,
  parameter string INIT_FILE = "rom.mif",
  localparam int   BC_W      = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic [BC_W-1:0]   burstcount,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic [1:0]        response,
  output logic [15:0]       accept_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int DLY_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BC_W-1:0]   beats_left_q, beats_left_d;
  logic [DLY_W-1:0]  delay_cnt_q, delay_cnt_d;
  logic              err_q, err_d;
  logic              waitreq_q, waitreq_d;
  logic              rom_v_q, rom_v_d;       // ROM q carries a beat this cycle
  logic              rom_last_q, rom_last_d;
  logic              rd_last_q, rd_last_d;   // final beat is on readdata this cycle
  logic              rdv_q, rdv_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic [1:0]        resp_q, resp_d;
  logic [15:0]       acc_q, acc_d;
  logic [DATA_W-1:0] rom_q;
  logic              cmd_err;

  assign cmd_err = (address >= ADDR_W'(DEPTH));

  rom_sync_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_rom (
    .clk    (clk),
    .reset_n(reset_n),
    .addr_i (idx_q),
    .q_o    (rom_q)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    beats_left_d = beats_left_q;
    delay_cnt_d  = delay_cnt_q;
    err_d        = err_q;
    waitreq_d    = waitreq_q;
    acc_d        = acc_q;
    rom_v_d      = 1'b0;
    rom_last_d   = 1'b0;
    rd_last_d    = rom_last_q;
    rdv_d        = rom_v_q;
    resp_d       = (rom_v_q && err_q) ? RESP_DECERR : RESP_OKAY;
    readdata_d   = rom_v_q ? (err_q ? '0 : rom_q) : readdata_q;

    unique case (state_q)
      IDLE: begin
        if (read) begin
          idx_d        = cmd_err ? '0 : address[IDX_W-1:0];
          beats_left_d = BC_W'(clamp_burst(32'(burstcount), MAX_BURST));
          err_d        = cmd_err;
          delay_cnt_d  = DLY_W'(DELAY);
          waitreq_d    = 1'b1;
          if (acc_q != 16'hFFFF) acc_d = acc_q + 16'd1;
          state_d      = (DELAY == 0) ? STREAM : WAIT;
        end
      end
      WAIT: begin
        delay_cnt_d = delay_cnt_q - 1'b1;
        if (delay_cnt_q == DLY_W'(1)) state_d = STREAM;
      end
      STREAM: begin
        if (beats_left_q != '0) begin
          rom_v_d      = 1'b1;
          rom_last_d   = (beats_left_q == BC_W'(1));
          beats_left_d = beats_left_q - 1'b1;
          idx_d        = (idx_q == IDX_W'(DEPTH - 1)) ? '0 : idx_q + 1'b1;
        end
        // Drop waitrequest so it falls together with the last readdatavalid.
        if (rom_last_q) waitreq_d = 1'b0;
        if (rd_last_q)  state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      beats_left_q <= '0;
      delay_cnt_q  <= '0;
      err_q        <= 1'b0;
      waitreq_q    <= 1'b0;
      rom_v_q      <= 1'b0;
      rom_last_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rdv_q        <= 1'b0;
      readdata_q   <= '0;
      resp_q       <= RESP_OKAY;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      beats_left_q <= beats_left_d;
      delay_cnt_q  <= delay_cnt_d;
      err_q        <= err_d;
      waitreq_q    <= waitreq_d;
      rom_v_q      <= rom_v_d;
      rom_last_q   <= rom_last_d;
      rd_last_q    <= rd_last_d;
      rdv_q        <= rdv_d;
      readdata_q   <= readdata_d;
      resp_q       <= resp_d;
      acc_q        <= acc_d;
    end
  end

  assign waitrequest   = waitreq_q;
  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;
  assign response      = resp_q;
  assign accept_count  = acc_q;

endmodule
